oeo_buf_ctrl: RTL and testbench
===============================

Name: oeo_buf_ctrl

Overview:
- Per-input-port controller for one OEO recirculation buffer in the speculative photonic network.
- Captures packets that lost output arbitration and queues them in packet-granular FIFO order.
- Issues exactly one buffer request per queued packet to the recirculation allocator's buffer request path, waits for the buffer grant, then replays the packet over one slot.
- One instance per port, sitting between the ingress no-grant path and the buffer-to-output photonic switch input.

Parameters:
PORTS, 8, number of network ports; destination field width is $clog2(PORTS)
SLOT_SIZE, 4, words per packet and cycles per switch slot
FIFO_DEPTH, 4, packets storable (power of 2, >=2)
DATA_W, 32, word width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  ingress word valid (packet arrives as SLOT_SIZE valid words)
in_port  in  $clog2(PORTS)  destination port, sampled on first word only
in_data  in  DATA_W  ingress word
grant_valid  in  1  registered buffer grant from the allocator for this port
req_valid  out  1  one-cycle buffer request pulse
req_port  out  $clog2(PORTS)  destination of head packet
out_valid  out  1  replay word valid
out_data  out  DATA_W  replay word
out_port  out  $clog2(PORTS)  destination of packet being replayed
count  out  $clog2(FIFO_DEPTH)+1  committed packets held
full  out  1  count==FIFO_DEPTH
ovf  out  1  one-cycle pulse: incoming packet dropped

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, pointers/word counters 0, memory contents don't-care.
- Storage: FIFO_DEPTH x SLOT_SIZE words plus FIFO_DEPTH destination entries; wr_ptr/rd_ptr wrap modulo FIFO_DEPTH.
- Ingress: wr_word counts valid words 0..SLOT_SIZE-1; gaps in in_valid hold the counter.
- On the first word (wr_word==0):
  - If full, the whole packet is discarded.
  - ovf pulses in the cycle after that first word.
  - The remaining SLOT_SIZE-1 words are counted and ignored.
- A packet commits on the edge accepting its last word: wr_ptr++, count++.
- Full is evaluated against committed count, not partially written packets.
- FSM, registered state:
  - IDLE: if count>0 -> REQ.
  - REQ: req_valid=1, req_port=dest[rd_ptr], exactly one cycle -> WAIT.
  - WAIT: hold; grant_valid=1 -> XMIT, rd_word=0.
  - XMIT: out_valid=1, out_data=mem[rd_ptr][rd_word], out_port=dest[rd_ptr]; rd_word++ each cycle.
  - On the cycle with rd_word==SLOT_SIZE-1: pop (rd_ptr++, count--). Go to REQ if count>1 before pop, else IDLE.
- req_valid, out_valid and out_port are decoded from the state register (glitch-free). req_port, out_port and out_data are 0 when the corresponding valid is low.
- Latency:
  - Last ingress word at cycle N -> req_valid at N+2 (from IDLE).
  - grant_valid at cycle G -> out_valid at G+1..G+SLOT_SIZE.
  - Back-to-back: next req_valid at G+SLOT_SIZE+1.
- Simultaneous commit and pop in the same cycle: count unchanged; full computed from the updated count.
- grant_valid outside WAIT is ignored, with no state change.
- The controller never re-issues a request for a packet already requested, because the allocator counts requests per message.
- rst asserted mid-XMIT or mid-ingress: all queued and partial packets are lost; outputs go to 0 immediately.

Optional Feature:
OEO_STATS_EN
- Defined:
  - Adds outputs stat_in, stat_out, stat_drop (each 16 bits).
  - They count committed, fully replayed, and ovf-dropped packets respectively.
  - Saturating at 16'hFFFF; async-reset to 0.
  - Each increments on the same edge as its event (commit, pop, ovf).
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
All tests use PORTS=4, SLOT_SIZE=4, FIFO_DEPTH=2, DATA_W=32.
- Single packet: in_port=2, words 0xA0..0xA3 at cycles 0-3 -> count=1 at cycle 4; req_valid=1, req_port=2 at cycle 5 only; grant_valid at cycle 8 -> out_valid cycles 9-12, out_data 0xA0..0xA3, out_port=2; count=0 at 13.
- Back-to-back: two packets (ports 1,3) queued, grant each -> second req_valid exactly one cycle after first replay ends, req_port=3; no duplicate pulses.
- Overflow: three packets with no grant -> full=1 after second; third drops, ovf single pulse one cycle after its first word; count stays 2; stat_drop=1 when OEO_STATS_EN.
- Simultaneous commit/pop: FIFO holds 2, third packet's last word lands in final XMIT cycle while first pops -> third accepted only if its first word arrived when count<2; otherwise dropped; count consistent (2).
- Spurious grant: grant_valid in IDLE and REQ -> no out_valid, state unchanged; later real grant in WAIT replays correctly.
- Async reset mid-XMIT after 2 words: rst low between edges -> out_valid, count, req_valid, full drop to 0 immediately; after release, new packet processes normally from pointer 0.

Source files
------------

// File: rtl/oeo_buf_ctrl.sv
// OEO recirculation buffer controller: queues packets that lost arbitration, requests a buffer per packet, replays on grant.
// Optional OEO_STATS_EN adds saturating commit/replay/drop counters (stat_in, stat_out, stat_drop).
module oeo_buf_ctrl #(
   parameter int unsigned PORTS      = 8,
   parameter int unsigned SLOT_SIZE  = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [$clog2(PORTS)-1:0]      in_port,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          grant_valid,
   output logic                          req_valid,
   output logic [$clog2(PORTS)-1:0]      req_port,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(PORTS)-1:0]      out_port,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          ovf
`ifdef OEO_STATS_EN
   ,
   output logic [15:0]                   stat_in,
   output logic [15:0]                   stat_out,
   output logic [15:0]                   stat_drop
`endif
);

   localparam int unsigned PW   = $clog2(PORTS);
   localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
   localparam int unsigned SW   = (SLOT_SIZE > 1) ? $clog2(SLOT_SIZE) : 1;
   localparam int unsigned CW   = PTRW + 1;
   localparam logic [SW-1:0] LAST_WORD = SW'(SLOT_SIZE - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, XMIT} state_t;

   state_t              state_q, state_d;
   logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]       wr_word_q, wr_word_d, rd_word_q, rd_word_d;
   logic                drop_q, drop_d;
   logic [CW-1:0]       count_q, count_d;
   logic                full_q, full_d;
   logic                ovf_q, ovf_d;
   logic                req_valid_q, req_valid_d, out_valid_q, out_valid_d;
   logic [PW-1:0]       req_port_q, req_port_d, out_port_q, out_port_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                first_w, pkt_drop, wr_en, commit, pop;

   logic [DATA_W-1:0]   mem_q  [FIFO_DEPTH][SLOT_SIZE];
   logic [PW-1:0]       dest_q [FIFO_DEPTH];

   // Ingress capture, replay FSM and registered output decode
   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      rd_word_d = rd_word_q;
      wr_ptr_d  = wr_ptr_q;
      wr_word_d = wr_word_q;
      drop_d    = drop_q;
      count_d   = count_q;
      wr_en     = 1'b0;
      commit    = 1'b0;
      pop       = 1'b0;
      first_w   = (wr_word_q == '0);
      pkt_drop  = first_w ? full_q : drop_q;
      ovf_d     = in_valid && first_w && full_q;

      if (in_valid) begin
         wr_en  = !pkt_drop;
         drop_d = pkt_drop;
         if (wr_word_q == LAST_WORD) begin
            wr_word_d = '0;
            commit    = !pkt_drop;
         end else begin
            wr_word_d = wr_word_q + SW'(1);
         end
      end
      if (commit) wr_ptr_d = wr_ptr_q + PTRW'(1);

      case (state_q)
         IDLE: if (count_q != '0) state_d = REQ;
         REQ:  state_d = WAIT;
         WAIT: if (grant_valid) begin
                  state_d   = XMIT;
                  rd_word_d = '0;
               end
         XMIT: if (rd_word_q == LAST_WORD) begin
                  pop       = 1'b1;
                  rd_ptr_d  = rd_ptr_q + PTRW'(1);
                  rd_word_d = '0;
                  state_d   = (count_q > CW'(1)) ? REQ : IDLE;
               end else begin
                  rd_word_d = rd_word_q + SW'(1);
               end
         default: state_d = IDLE;
      endcase

      if (commit && !pop)      count_d = count_q + CW'(1);
      else if (!commit && pop) count_d = count_q - CW'(1);
      full_d = (count_d == CW'(FIFO_DEPTH));

      req_valid_d = (state_d == REQ);
      req_port_d  = req_valid_d ? dest_q[rd_ptr_d] : '0;
      out_valid_d = (state_d == XMIT);
      out_port_d  = out_valid_d ? dest_q[rd_ptr_d] : '0;
      out_data_d  = out_valid_d ? mem_q[rd_ptr_d][rd_word_d] : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         wr_word_q   <= '0;
         rd_word_q   <= '0;
         drop_q      <= 1'b0;
         count_q     <= '0;
         full_q      <= 1'b0;
         ovf_q       <= 1'b0;
         req_valid_q <= 1'b0;
         req_port_q  <= '0;
         out_valid_q <= 1'b0;
         out_port_q  <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_word_q   <= wr_word_d;
         rd_word_q   <= rd_word_d;
         drop_q      <= drop_d;
         count_q     <= count_d;
         full_q      <= full_d;
         ovf_q       <= ovf_d;
         req_valid_q <= req_valid_d;
         req_port_q  <= req_port_d;
         out_valid_q <= out_valid_d;
         out_port_q  <= out_port_d;
         out_data_q  <= out_data_d;
      end
   end

   // Packet storage needs no reset; the head slot is always committed before it is read
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q][wr_word_q] <= in_data;
         if (first_w) dest_q[wr_ptr_q] <= in_port;
      end
   end

   assign req_valid = req_valid_q;
   assign req_port  = req_port_q;
   assign out_valid = out_valid_q;
   assign out_port  = out_port_q;
   assign out_data  = out_data_q;
   assign count     = count_q;
   assign full      = full_q;
   assign ovf       = ovf_q;

`ifdef OEO_STATS_EN
   logic [15:0] stat_in_q, stat_out_q, stat_drop_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_in_q   <= '0;
         stat_out_q  <= '0;
         stat_drop_q <= '0;
      end else begin
         if (commit && (stat_in_q != 16'hFFFF))  stat_in_q   <= stat_in_q + 16'd1;
         if (pop && (stat_out_q != 16'hFFFF))    stat_out_q  <= stat_out_q + 16'd1;
         if (ovf_d && (stat_drop_q != 16'hFFFF)) stat_drop_q <= stat_drop_q + 16'd1;
      end
   end

   assign stat_in   = stat_in_q;
   assign stat_out  = stat_out_q;
   assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_oeo_buf_ctrl.sv
// Directed vector bench for oeo_buf_ctrl (PORTS=4, SLOT_SIZE=4, FIFO_DEPTH=2, DATA_W=32).
module tb_oeo_buf_ctrl;

   localparam int unsigned PORTS      = 4;
   localparam int unsigned SLOT_SIZE  = 4;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned DATA_W     = 32;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [1:0]  in_port;
   logic [31:0] in_data;
   logic        grant_valid;
   logic        req_valid;
   logic [1:0]  req_port;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_port;
   logic [1:0]  count;
   logic        full;
   logic        ovf;
`ifdef OEO_STATS_EN
   logic [15:0] stat_in, stat_out, stat_drop;
`endif

   oeo_buf_ctrl #(
      .PORTS(PORTS), .SLOT_SIZE(SLOT_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_port(in_port), .in_data(in_data),
      .grant_valid(grant_valid), .req_valid(req_valid), .req_port(req_port),
      .out_valid(out_valid), .out_data(out_data), .out_port(out_port),
      .count(count), .full(full), .ovf(ovf)
`ifdef OEO_STATS_EN
      , .stat_in(stat_in), .stat_out(stat_out), .stat_drop(stat_drop)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [1:0]  ip;
      logic [31:0] id;
      logic        g;
      logic        rv;
      logic [1:0]  rp;
      logic        ov;
      logic [31:0] od;
      logic [1:0]  op;
      logic [1:0]  cnt;
      logic        fl;
      logic        of;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic iv, input int ip, input int id, input logic g,
                               input logic rv, input int rp, input logic ov, input int od,
                               input int op, input int cnt, input logic fl, input logic of);
      vec_t v;
      v.iv = iv;  v.ip = 2'(ip);  v.id = 32'(id);  v.g = g;
      v.rv = rv;  v.rp = 2'(rp);  v.ov = ov;       v.od = 32'(od);
      v.op = 2'(op); v.cnt = 2'(cnt); v.fl = fl;   v.of = of;
      return v;
   endfunction

   task automatic add(input logic iv, input int ip, input int id, input logic g,
                      input logic rv, input int rp, input logic ov, input int od,
                      input int op, input int cnt, input logic fl, input logic of);
      vq.push_back(mk(iv, ip, id, g, rv, rp, ov, od, op, cnt, fl, of));
   endtask

   task automatic cmp(input string tag, input int idx, input string f,
                      input logic [31:0] got, input logic [31:0] want);
      if (got !== want) begin
         n_err++;
         $display("FAIL %s[%0d] %s: got %0h, expected %0h", tag, idx, f, got, want);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid    = v.iv;
      in_port     = v.ip;
      in_data     = v.id;
      grant_valid = v.g;
   endtask

   task automatic check(input vec_t v, input string tag, input int idx);
      n_vec++;
      cmp(tag, idx, "req_valid", 32'(req_valid), 32'(v.rv));
      cmp(tag, idx, "req_port",  32'(req_port),  32'(v.rp));
      cmp(tag, idx, "out_valid", 32'(out_valid), 32'(v.ov));
      cmp(tag, idx, "out_data",  out_data,       v.od);
      cmp(tag, idx, "out_port",  32'(out_port),  32'(v.op));
      cmp(tag, idx, "count",     32'(count),     32'(v.cnt));
      cmp(tag, idx, "full",      32'(full),      32'(v.fl));
      cmp(tag, idx, "ovf",       32'(ovf),       32'(v.of));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i]);
         check(vq[i], tag, i);
         tick();
      end
      vq.delete();
   endtask

`ifdef OEO_STATS_EN
   task automatic check_stats(input string tag, input int e_in, input int e_out, input int e_drop);
      n_vec++;
      cmp(tag, 0, "stat_in",   32'(stat_in),   32'(e_in));
      cmp(tag, 0, "stat_out",  32'(stat_out),  32'(e_out));
      cmp(tag, 0, "stat_drop", 32'(stat_drop), 32'(e_drop));
   endtask
`endif

   initial begin
      vec_t z;
      z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      drive(z);
      repeat (3) @(posedge clk);
      #1;
      check(z, "reset", 0);
      rst = 1'b1;

      // Single packet: req at N+2, replay G+1..G+4
      for (int i = 0; i < 4; i++) add(1, 2, 'hA0 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'hA0 + i, 2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run("single");

      // Back-to-back packets to ports 1 and 3
      for (int i = 0; i < 4; i++) add(1, 1, 'hB0 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 3, 'hC0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 3, 'hC1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 3, 'hC2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 3, 'hC3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'hB0 + i, 1, 2, 1, 0);
      add(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'hC0 + i, 3, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run("b2b");

      // Overflow on the third packet, then spurious grants in REQ and IDLE
      for (int i = 0; i < 4; i++) add(1, 1, 'hE0 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 2, 'hF0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'hF1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'hF2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'hF3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 3, 'h60, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      add(1, 3, 'h61, 0, 0, 0, 0, 0, 0, 2, 1, 1);
      add(1, 3, 'h62, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      add(1, 3, 'h63, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'hE0 + i, 1, 2, 1, 0);
      add(0, 0, 0, 1, 1, 2, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'hF0 + i, 2, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run("ovf");

      // Third packet starts while full and ends on the pop edge: dropped
      for (int i = 0; i < 4; i++) add(1, 1, 'h10 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 2, 'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'h21, 0, 1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'h22, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'h23, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0);
      add(1, 3, 'h30, 0, 0, 0, 1, 'h10, 1, 2, 1, 0);
      add(1, 3, 'h31, 0, 0, 0, 1, 'h11, 1, 2, 1, 1);
      add(1, 3, 'h32, 0, 0, 0, 1, 'h12, 1, 2, 1, 0);
      add(1, 3, 'h33, 0, 0, 0, 1, 'h13, 1, 2, 1, 0);
      add(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'h20 + i, 2, 1, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run("pop_drop");

      // Second packet starts with room and commits on the pop edge: accepted
      for (int i = 0; i < 4; i++) add(1, 1, 'h40 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(1, 2, 'h50 + i, 0, 0, 0, 1, 'h40 + i, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'h50 + i, 2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run("pop_accept");

`ifdef OEO_STATS_EN
      check_stats("stats_pre_rst", 9, 9, 2);
`endif

      // Async reset mid-replay with the FIFO full
      for (int i = 0; i < 4; i++) add(1, 1, 'h70 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 2, 'h80, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'h81, 0, 1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'h82, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 2, 'h83, 0, 0, 0, 1, 'h70, 1, 1, 0, 0);
      run("rst_pre");
      drive(z);
      check(mk(0, 0, 0, 0, 0, 0, 1, 'h71, 1, 2, 1, 0), "rst_mid", 0);
      #2;
      rst = 1'b0;
      #1;
      check(z, "rst_async", 0);
      tick();
      check(z, "rst_hold", 0);
      rst = 1'b1;

      for (int i = 0; i < 4; i++) add(1, 3, 'h90 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 'h90 + i, 3, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run("post_rst");

`ifdef OEO_STATS_EN
      check_stats("stats_post_rst", 1, 1, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
